// File: rtl/mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared types and constants for the two-requester block-RAM access
// controller.
//   state_t    : controller FSM states
//   req_id_t   : requester identifier (0 = r0 fetch, 1 = r1 load/store)
//   SEL_*      : bank-select codes formed as {bank, we}
//   bank_sel() : builds a bank-select code from bank bit and write flag
// ---------------------------------------------------------------------------
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef logic req_id_t;

    localparam logic [1:0] SEL_B1_RD = 2'b00;
    localparam logic [1:0] SEL_B1_WR = 2'b01;
    localparam logic [1:0] SEL_B2_RD = 2'b10;
    localparam logic [1:0] SEL_B2_WR = 2'b11;

    function automatic logic [1:0] bank_sel(input logic bank, input logic we);
        return {bank, we};
    endfunction

endpackage

// File: rtl/mem_bank_decode.sv
// ---------------------------------------------------------------------------
// mem_bank_decode
// Turns a bank-select code into the four block-RAM strobes. Purely
// combinational; every strobe is low while 'active' is low, so the caller
// only has to raise 'active' during the one cycle an access is issued.
// Ports:
//   active     in   1  access issued this cycle
//   sel        in   2  {bank, we}: bank 0 = bank1, bank 1 = bank2
//   bank1_ena  out  1  bank1 enable
//   bank1_wea  out  1  bank1 write enable
//   bank2_ena  out  1  bank2 enable
//   bank2_wea  out  1  bank2 write enable
// ---------------------------------------------------------------------------
module mem_bank_decode
    import mem_ctrl_pkg::*;
(
    input  logic       active,
    input  logic [1:0] sel,
    output logic       bank1_ena,
    output logic       bank1_wea,
    output logic       bank2_ena,
    output logic       bank2_wea
);

    // Decode the select code into strobes. At most one bank is ever enabled
    // because each code maps to a single bank, and a write enable is only
    // raised together with the enable of the same bank.
    always_comb begin
        bank1_ena = 1'b0;
        bank1_wea = 1'b0;
        bank2_ena = 1'b0;
        bank2_wea = 1'b0;
        if (active) begin
            case (sel)
                SEL_B1_RD: begin
                    bank1_ena = 1'b1;
                end
                SEL_B1_WR: begin
                    bank1_ena = 1'b1;
                    bank1_wea = 1'b1;
                end
                SEL_B2_RD: begin
                    bank2_ena = 1'b1;
                end
                SEL_B2_WR: begin
                    bank2_ena = 1'b1;
                    bank2_wea = 1'b1;
                end
                default: begin
                    bank1_ena = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
// Shares a two-bank block-RAM store between r0 (instruction fetch) and
// r1 (data load/store). Requests are arbitrated round-robin, each accepted
// request issues exactly one single-cycle bank access, and read data is
// returned to the requester after the bank read latency. Accesses are
// strictly sequential: a write takes 2 cycles, a read RD_LAT+3.
// Parameters:
//   ADDR_W  per-bank word address width (requester address has one extra
//           MSB selecting the bank: 0 = bank1, 1 = bank2)
//   DATA_W  data word width
//   RD_LAT  bank read latency in cycles, 1..3
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   rN_req/we/addr/wdata  in    request from requester N (N = 0, 1)
//   rN_gnt                out   one-cycle pulse, access issued this cycle
//   rN_rvalid             out   one-cycle pulse, rN_rdata valid
//   rN_rdata              out   read data, held until the next rN_rvalid
//   bankX_ena/bankX_wea   out   bank strobes
//   mem_addr, mem_wdata   out   shared bank address and write data
//   bankX_rdata           in    bank read data
// ---------------------------------------------------------------------------
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W:0]   r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W:0]   r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              bank1_ena,
    output logic              bank1_wea,
    output logic              bank2_ena,
    output logic              bank2_wea,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] bank1_rdata,
    input  logic [DATA_W-1:0] bank2_rdata
);

    localparam logic [1:0] LAT_INIT = 2'(RD_LAT);

    state_t            state;
    state_t            state_next;
    req_id_t           win_id;
    req_id_t           lat_id;
    req_id_t           last_id;
    logic              lat_we;
    logic [ADDR_W:0]   lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [1:0]        cnt;
    logic              any_req;
    logic              cnt_done;
    logic              access_active;
    logic [1:0]        access_sel;
    logic [DATA_W-1:0] bank_rdata;

    assign any_req       = r0_req | r1_req;
    assign cnt_done      = (cnt == 2'd1);
    assign access_active = (state == ACCESS);
    assign access_sel    = bank_sel(lat_addr[ADDR_W], lat_we);
    assign bank_rdata    = lat_addr[ADDR_W] ? bank2_rdata : bank1_rdata;
    assign mem_addr      = lat_addr[ADDR_W-1:0];
    assign mem_wdata     = lat_wdata;

    // Round-robin pick. A lone requester always wins; on a tie the
    // requester that was not granted last goes first. last_id resets to r1
    // so r0 takes the very first tie after reset.
    always_comb begin
        win_id = r1_req;
        if (r0_req && r1_req) begin
            win_id = ~last_id;
        end
    end

    // State register. Reset lands in IDLE, which also drops any read still
    // waiting on the bank, so an aborted read never reaches RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs. Grant is shown in ACCESS, the same
    // cycle the bank strobes go out; rvalid is shown in RESP, one cycle
    // after the read data was captured. WAIT runs for RD_LAT cycles and
    // leaves on the cycle the latency counter reaches zero.
    always_comb begin
        state_next = state;
        r0_gnt     = 1'b0;
        r1_gnt     = 1'b0;
        r0_rvalid  = 1'b0;
        r1_rvalid  = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                r0_gnt     = (lat_id == 1'b0);
                r1_gnt     = (lat_id == 1'b1);
                state_next = lat_we ? IDLE : WAIT;
            end
            WAIT: begin
                if (cnt_done) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                r0_rvalid  = (lat_id == 1'b0);
                r1_rvalid  = (lat_id == 1'b1);
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers. The winner's request is latched in IDLE so the
    // requester may change or drop its inputs once arbitration has
    // happened. The round-robin pointer moves when the grant is actually
    // issued. In WAIT the counter counts the bank latency down and, on the
    // cycle it reaches zero, the selected bank's output is stored in the
    // winner's read register; the other requester's register is untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_id    <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            last_id   <= 1'b1;
            cnt       <= 2'd0;
            r0_rdata  <= '0;
            r1_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        lat_id <= win_id;
                        if (win_id) begin
                            lat_we    <= r1_we;
                            lat_addr  <= r1_addr;
                            lat_wdata <= r1_wdata;
                        end else begin
                            lat_we    <= r0_we;
                            lat_addr  <= r0_addr;
                            lat_wdata <= r0_wdata;
                        end
                    end
                end
                ACCESS: begin
                    last_id <= lat_id;
                    if (!lat_we) begin
                        cnt <= LAT_INIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 2'd1;
                    if (cnt_done) begin
                        if (lat_id) begin
                            r1_rdata <= bank_rdata;
                        end else begin
                            r0_rdata <= bank_rdata;
                        end
                    end
                end
                default: begin
                    cnt <= cnt;
                end
            endcase
        end
    end

    mem_bank_decode u_decode (
        .active    (access_active),
        .sel       (access_sel),
        .bank1_ena (bank1_ena),
        .bank1_wea (bank1_wea),
        .bank2_ena (bank2_ena),
        .bank2_wea (bank2_wea)
    );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
// Two controller instances share the clock: inst0 with RD_LAT=1 and inst1
// with RD_LAT=3, each with its own behavioural two-bank memory and reset.
// Stimulus pushes hand-computed grant/rvalid events into a per-instance
// queue; a negedge monitor pops and compares whenever a grant or rvalid
// appears, and checks strobe legality on every strobe cycle.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

    localparam int AW = 10;
    localparam int DW = 32;

    typedef struct {
        bit            kind;
        bit            id;
        bit [3:0]      ena;
        logic [AW-1:0] addr;
        bit            chkW;
        logic [DW-1:0] data;
        int            cyc;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst_n   [2];
    logic          r0_req  [2];
    logic          r0_we   [2];
    logic [AW:0]   r0_addr [2];
    logic [DW-1:0] r0_wdata[2];
    logic          r1_req  [2];
    logic          r1_we   [2];
    logic [AW:0]   r1_addr [2];
    logic [DW-1:0] r1_wdata[2];
    logic          r0_gnt   [2];
    logic          r0_rvalid[2];
    logic [DW-1:0] r0_rdata [2];
    logic          r1_gnt   [2];
    logic          r1_rvalid[2];
    logic [DW-1:0] r1_rdata [2];
    logic          b1e[2];
    logic          b1w[2];
    logic          b2e[2];
    logic          b2w[2];
    logic [AW-1:0] maddr [2];
    logic [DW-1:0] mwdata[2];
    logic [DW-1:0] b1rd[2];
    logic [DW-1:0] b2rd[2];

    logic [DW-1:0] mem1[2][1024];
    logic [DW-1:0] mem2[2][1024];
    logic [DW-1:0] p1[2][3];
    logic [DW-1:0] p2[2][3];
    bit            memInit = 1'b0;

    ev_t           q0[$];
    ev_t           q1[$];
    logic [DW-1:0] expHeld[2][2];
    int            cyc = 0;
    int            nChecks = 0;
    int            nFails = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut0 (
        .clk(clk), .rst_n(rst_n[0]),
        .r0_req(r0_req[0]), .r0_we(r0_we[0]), .r0_addr(r0_addr[0]), .r0_wdata(r0_wdata[0]),
        .r1_req(r1_req[0]), .r1_we(r1_we[0]), .r1_addr(r1_addr[0]), .r1_wdata(r1_wdata[0]),
        .r0_gnt(r0_gnt[0]), .r0_rvalid(r0_rvalid[0]), .r0_rdata(r0_rdata[0]),
        .r1_gnt(r1_gnt[0]), .r1_rvalid(r1_rvalid[0]), .r1_rdata(r1_rdata[0]),
        .bank1_ena(b1e[0]), .bank1_wea(b1w[0]), .bank2_ena(b2e[0]), .bank2_wea(b2w[0]),
        .mem_addr(maddr[0]), .mem_wdata(mwdata[0]),
        .bank1_rdata(b1rd[0]), .bank2_rdata(b2rd[0])
    );

    mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut1 (
        .clk(clk), .rst_n(rst_n[1]),
        .r0_req(r0_req[1]), .r0_we(r0_we[1]), .r0_addr(r0_addr[1]), .r0_wdata(r0_wdata[1]),
        .r1_req(r1_req[1]), .r1_we(r1_we[1]), .r1_addr(r1_addr[1]), .r1_wdata(r1_wdata[1]),
        .r0_gnt(r0_gnt[1]), .r0_rvalid(r0_rvalid[1]), .r0_rdata(r0_rdata[1]),
        .r1_gnt(r1_gnt[1]), .r1_rvalid(r1_rvalid[1]), .r1_rdata(r1_rdata[1]),
        .bank1_ena(b1e[1]), .bank1_wea(b1w[1]), .bank2_ena(b2e[1]), .bank2_wea(b2w[1]),
        .mem_addr(maddr[1]), .mem_wdata(mwdata[1]),
        .bank1_rdata(b1rd[1]), .bank2_rdata(b2rd[1])
    );

    // Behavioural banks: word i of bank1 starts as 0x1000_0000+i, of bank2
    // as 0x2000_0000+i. A read loads stage 0 on the enable edge and the
    // pipe advances every cycle; inst0 taps stage 0, inst1 taps stage 2.
    always @(posedge clk) begin
        if (!memInit) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 1024; i++) begin
                    mem1[k][i] <= 32'h1000_0000 + 32'(i);
                    mem2[k][i] <= 32'h2000_0000 + 32'(i);
                end
            end
            memInit <= 1'b1;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (b1e[k]) begin
                    if (b1w[k]) mem1[k][maddr[k]] <= mwdata[k];
                    else p1[k][0] <= mem1[k][maddr[k]];
                end
                if (b2e[k]) begin
                    if (b2w[k]) mem2[k][maddr[k]] <= mwdata[k];
                    else p2[k][0] <= mem2[k][maddr[k]];
                end
                p1[k][1] <= p1[k][0];
                p1[k][2] <= p1[k][1];
                p2[k][1] <= p2[k][0];
                p2[k][2] <= p2[k][1];
            end
        end
    end

    assign b1rd[0] = p1[0][0];
    assign b2rd[0] = p2[0][0];
    assign b1rd[1] = p1[1][2];
    assign b2rd[1] = p2[1][2];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pushEv(input int k, input ev_t e);
        if (k == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    function automatic bit popEv(input int k, output ev_t e);
        e = '{default: 0};
        if (k == 0) begin
            if (q0.size() == 0) return 1'b0;
            e = q0.pop_front();
        end else begin
            if (q1.size() == 0) return 1'b0;
            e = q1.pop_front();
        end
        return 1'b1;
    endfunction

    task automatic expectGnt(input int k, input bit id, input bit [3:0] ena, input logic [AW-1:0] addr,
                             input bit chkW, input logic [DW-1:0] wdata, input int c);
        ev_t e;
        e.kind = 1'b0; e.id = id; e.ena = ena; e.addr = addr;
        e.chkW = chkW; e.data = wdata; e.cyc = c;
        pushEv(k, e);
    endtask

    task automatic expectRv(input int k, input bit id, input logic [DW-1:0] data, input int c);
        ev_t e;
        e.kind = 1'b1; e.id = id; e.ena = 4'b0; e.addr = '0;
        e.chkW = 1'b0; e.data = data; e.cyc = c;
        pushEv(k, e);
    endtask

    task automatic monitorInst(input int k);
        logic       g0, g1, v0, v1, ok;
        logic [3:0] en;
        ev_t        e;
        g0 = r0_gnt[k];
        g1 = r1_gnt[k];
        v0 = r0_rvalid[k];
        v1 = r1_rvalid[k];
        en = {b1e[k], b1w[k], b2e[k], b2w[k]};
        if (en != 4'b0 || g0 || g1) begin
            ok = (g0 ^ g1) && (b1e[k] ^ b2e[k]) && !(b1w[k] && !b1e[k]) && !(b2w[k] && !b2e[k]);
            checkOutput($sformatf("inst%0d strobe legality en=%b gnt=%b%b", k, en, g0, g1), 64'(ok), 64'd1);
        end
        if (g0 || g1) begin
            if (popEv(k, e)) begin
                checkOutput($sformatf("inst%0d event kind at grant", k), 64'd0, 64'(e.kind));
                checkOutput($sformatf("inst%0d gnt id", k), 64'(g1), 64'(e.id));
                checkOutput($sformatf("inst%0d gnt bank strobes", k), 64'(en), 64'(e.ena));
                checkOutput($sformatf("inst%0d gnt mem_addr", k), 64'(maddr[k]), 64'(e.addr));
                if (e.chkW) checkOutput($sformatf("inst%0d gnt mem_wdata", k), 64'(mwdata[k]), 64'(e.data));
                if (e.cyc >= 0) checkOutput($sformatf("inst%0d gnt cycle", k), 64'(cyc), 64'(e.cyc));
            end else begin
                nChecks++;
                nFails++;
                $display("[TB] FAIL inst%0d unexpected grant: got gnt=%b%b, required none (cycle %0d)", k, g0, g1, cyc);
            end
        end
        if (v0 || v1) begin
            checkOutput($sformatf("inst%0d rvalid both high", k), 64'(v0 & v1), 64'd0);
            if (popEv(k, e)) begin
                checkOutput($sformatf("inst%0d event kind at rvalid", k), 64'd1, 64'(e.kind));
                checkOutput($sformatf("inst%0d rvalid id", k), 64'(v1), 64'(e.id));
                checkOutput($sformatf("inst%0d rdata r%0d", k, e.id),
                            64'(e.id ? r1_rdata[k] : r0_rdata[k]), 64'(e.data));
                checkOutput($sformatf("inst%0d held rdata r%0d", k, e.id ? 0 : 1),
                            64'(e.id ? r0_rdata[k] : r1_rdata[k]), 64'(expHeld[k][e.id ? 0 : 1]));
                if (e.cyc >= 0) checkOutput($sformatf("inst%0d rvalid cycle", k), 64'(cyc), 64'(e.cyc));
                expHeld[k][e.id ? 1 : 0] = e.data;
            end else begin
                nChecks++;
                nFails++;
                $display("[TB] FAIL inst%0d unexpected rvalid: got rvalid=%b%b, required none (cycle %0d)", k, v0, v1, cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        monitorInst(0);
        monitorInst(1);
    end

    task automatic driveReq(input int k, input bit id, input bit req, input bit we,
                            input logic [AW:0] addr, input logic [DW-1:0] wdata);
        if (id) begin
            r1_req[k] = req; r1_we[k] = we; r1_addr[k] = addr; r1_wdata[k] = wdata;
        end else begin
            r0_req[k] = req; r0_we[k] = we; r0_addr[k] = addr; r0_wdata[k] = wdata;
        end
    endtask

    task automatic checkQuiet(input int k, input string name);
        checkOutput($sformatf("inst%0d %s strobes", k, name),
                    64'({r0_gnt[k], r1_gnt[k], r0_rvalid[k], r1_rvalid[k], b1e[k], b1w[k], b2e[k], b2w[k]}), 64'd0);
    endtask

    // Called just after a rising edge with the addressed instance idle:
    // raises the request, queues the expected events, drops the request once
    // the grant is seen, then waits holdCycles rising edges.
    task automatic applyStimulus(input int k, input bit id, input bit we, input logic [AW:0] addr,
                                 input logic [DW-1:0] wdata, input bit [3:0] expEna,
                                 input logic [AW-1:0] expAddr, input logic [DW-1:0] expData,
                                 input bit withRv, input int holdCycles);
        int t;
        int lat;
        bit seen;
        lat = (k == 0) ? 1 : 3;
        t = cyc;
        driveReq(k, id, 1'b1, we, addr, wdata);
        expectGnt(k, id, expEna, expAddr, we, wdata, t + 1);
        if (!we && withRv) expectRv(k, id, expData, t + 2 + lat);
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            seen = id ? r1_gnt[k] : r0_gnt[k];
        end
        driveReq(k, id, 1'b0, we, addr, wdata);
        checkOutput($sformatf("inst%0d r%0d grant within bound", k, id), 64'(seen), 64'd1);
        repeat (holdCycles) @(posedge clk);
        #1;
    endtask

    initial begin
        int r;
        int t;
        int gcount;
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0;
            driveReq(k, 1'b0, 1'b0, 1'b0, '0, '0);
            driveReq(k, 1'b1, 1'b0, 1'b0, '0, '0);
            expHeld[k][0] = '0;
            expHeld[k][1] = '0;
        end

        // inst0: reset with both requests high, then fairness on reads
        driveReq(0, 1'b0, 1'b1, 1'b0, 11'h003, 32'h0);
        driveReq(0, 1'b1, 1'b1, 1'b0, 11'h407, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkQuiet(0, "in reset");
        checkOutput("inst0 reset mem_addr/rdata", 64'({maddr[0], r0_rdata[0] | r1_rdata[0]}), 64'd0);
        @(posedge clk);
        #1;
        r = cyc;
        expectGnt(0, 1'b0, 4'b1000, 10'h003, 1'b0, 32'h0, r + 1);
        expectRv (0, 1'b0, 32'h1000_0003, r + 3);
        expectGnt(0, 1'b1, 4'b0010, 10'h007, 1'b0, 32'h0, r + 5);
        expectRv (0, 1'b1, 32'h2000_0007, r + 7);
        expectGnt(0, 1'b0, 4'b1000, 10'h003, 1'b0, 32'h0, r + 9);
        expectRv (0, 1'b0, 32'h1000_0003, r + 11);
        expectGnt(0, 1'b1, 4'b0010, 10'h007, 1'b0, 32'h0, r + 13);
        expectRv (0, 1'b1, 32'h2000_0007, r + 15);
        rst_n[0] = 1'b1;
        @(negedge clk);
        checkQuiet(0, "first cycle after release");
        gcount = 0;
        for (int i = 0; i < 40 && gcount < 4; i++) begin
            @(negedge clk);
            if (r0_gnt[0] || r1_gnt[0]) gcount++;
        end
        driveReq(0, 1'b0, 1'b0, 1'b0, '0, '0);
        driveReq(0, 1'b1, 1'b0, 1'b0, '0, '0);
        checkOutput("inst0 four fairness grants within bound", 64'(gcount), 64'd4);
        repeat (6) @(posedge clk);
        #1;

        // inst0 directed accesses (RD_LAT=1)
        applyStimulus(0, 1'b0, 1'b1, 11'h005, 32'hDEAD_BEEF, 4'b1100, 10'h005, 32'h0, 1'b0, 4);
        applyStimulus(0, 1'b1, 1'b0, 11'h005, 32'h0, 4'b1000, 10'h005, 32'hDEAD_BEEF, 1'b1, 4);
        applyStimulus(0, 1'b1, 1'b0, 11'h405, 32'h0, 4'b0010, 10'h005, 32'h2000_0005, 1'b1, 4);
        applyStimulus(0, 1'b1, 1'b1, 11'h40A, 32'hCAFE_F00D, 4'b0011, 10'h00A, 32'h0, 1'b0, 4);
        applyStimulus(0, 1'b0, 1'b0, 11'h40A, 32'h0, 4'b0010, 10'h00A, 32'hCAFE_F00D, 1'b1, 4);
        applyStimulus(0, 1'b0, 1'b0, 11'h3FF, 32'h0, 4'b1000, 10'h3FF, 32'h1000_03FF, 1'b1, 4);
        applyStimulus(0, 1'b1, 1'b0, 11'h7FF, 32'h0, 4'b0010, 10'h3FF, 32'h2000_03FF, 1'b1, 4);

        // inst1: RD_LAT=3, normal read, reset mid-read, recovery
        rst_n[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(1, 1'b0, 1'b0, 11'h002, 32'h0, 4'b1000, 10'h002, 32'h1000_0002, 1'b1, 6);
        t = cyc;
        applyStimulus(1, 1'b0, 1'b0, 11'h006, 32'h0, 4'b1000, 10'h006, 32'h0, 1'b0, 2);
        checkOutput("inst1 abort pulse timing", 64'(cyc), 64'(t + 3));
        rst_n[1] = 1'b0;
        expHeld[1][0] = '0;
        expHeld[1][1] = '0;
        @(negedge clk);
        checkQuiet(1, "mid-read reset");
        checkOutput("inst1 rdata cleared by reset", 64'(r0_rdata[1]), 64'd0);
        @(posedge clk);
        #1;
        rst_n[1] = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        applyStimulus(1, 1'b1, 1'b0, 11'h409, 32'h0, 4'b0010, 10'h009, 32'h2000_0009, 1'b1, 6);
        applyStimulus(1, 1'b1, 1'b1, 11'h001, 32'h1234_5678, 4'b1100, 10'h001, 32'h0, 1'b0, 6);
        applyStimulus(1, 1'b0, 1'b0, 11'h001, 32'h0, 4'b1000, 10'h001, 32'h1234_5678, 1'b1, 6);

        repeat (4) @(posedge clk);
        checkOutput("inst0 outstanding expected events", 64'(q0.size()), 64'd0);
        checkOutput("inst1 outstanding expected events", 64'(q1.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no end of test by cycle %0d, required completion", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
